// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    START,
    RUN
  } loader_state_t;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned INSTR_W_DEF = 9;

  // A length byte of zero loads the full 2^ADDR_W-word memory
  localparam bit HDR_ZERO_MEANS_FULL = 1'b1;

  // Mask of the hi-byte bits that land in an INSTR_W-bit word (INSTR_W in 9..16)
  function automatic logic [7:0] hi_keep_mask(input int unsigned instr_w);
    return 8'((16'd1 << (instr_w - 32'd8)) - 16'd1);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write port and CPU control bundle of the loader.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) ();

  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               cpu_start;
  logic               cpu_halt;
  logic               busy;
  logic               done;
  logic               err;

  // Loader side
  modport master (
    input  in_valid,
    input  in_data,
    input  cpu_halt,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata,
    output cpu_start,
    output busy,
    output done,
    output err
  );

  // Stream source, memory and CPU side
  modport slave (
    output in_valid,
    output in_data,
    output cpu_halt,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata,
    input  cpu_start,
    input  busy,
    input  done,
    input  err
  );

endinterface

// File: rtl/imem_loader.sv
// Program loader: unpacks a length-prefixed byte stream into instruction words,
// writes them from address 0 upward, then starts the CPU and waits for halt.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.master bus
);

  // Remaining-word counter must hold 2^ADDR_W and any 8-bit length
  localparam int unsigned CntW = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
  localparam logic [CntW-1:0] FullCnt = CntW'(1) << ADDR_W;
  localparam logic [7:0] HiMask = hi_keep_mask(INSTR_W);

  loader_state_t      r_state;
  logic [CntW-1:0]    r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_lo;
  logic               r_we;
  logic [ADDR_W-1:0]  r_waddr;
  logic [INSTR_W-1:0] r_wdata;
  logic               r_start;
  logic               r_done;
  logic               r_err;

  loader_state_t      w_state_nxt;
  logic [CntW-1:0]    w_cnt_nxt;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [7:0]         w_lo_nxt;
  logic               w_we_nxt;
  logic [ADDR_W-1:0]  w_waddr_nxt;
  logic [INSTR_W-1:0] w_wdata_nxt;
  logic               w_start_nxt;
  logic               w_done_nxt;
  logic               w_err_nxt;
  logic               w_ready;
  logic               w_accept;

  assign w_ready  = (r_state == IDLE) || (r_state == LO) || (r_state == HI);
  assign w_accept = bus.in_valid && w_ready;

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_lo_nxt    = r_lo;
    w_we_nxt    = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    w_start_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = (HDR_ZERO_MEANS_FULL && (bus.in_data == 8'h00)) ?
                        FullCnt : CntW'(bus.in_data);
          w_addr_nxt  = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = LO;
        end
      end
      LO: begin
        if (w_accept) begin
          w_lo_nxt    = bus.in_data;
          w_state_nxt = HI;
        end
      end
      HI: begin
        if (w_accept) begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = r_addr;
          // Hi bits beyond the word width are dropped but flagged
          w_wdata_nxt = INSTR_W'({bus.in_data & HiMask, r_lo});
          w_err_nxt   = r_err | (|(bus.in_data & ~HiMask));
          w_addr_nxt  = r_addr + ADDR_W'(1);
          w_cnt_nxt   = r_cnt - CntW'(1);
          if (r_cnt == CntW'(1)) begin
            // Start pulse lands in the same cycle as the final write
            w_state_nxt = START;
            w_start_nxt = 1'b1;
          end else begin
            w_state_nxt = LO;
          end
        end
      end
      START: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        if (bus.cpu_halt) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_lo    <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_lo    <= w_lo_nxt;
      r_we    <= w_we_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
      r_start <= w_start_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.busy       = (r_state != IDLE);
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_waddr;
  assign bus.imem_wdata = r_wdata;
  assign bus.cpu_start  = r_start;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader at ADDR_W=8, INSTR_W=9.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  imem_loader_if #(.ADDR_W(8), .INSTR_W(9)) ifc ();

  imem_loader #(.ADDR_W(8), .INSTR_W(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, sampled mid-cycle
  logic [7:0] wq_addr[$];
  logic [8:0] wq_data[$];
  int         wq_cyc[$];
  int         sq_cyc[$];
  int         dq_cyc[$];
  int         done_cnt = 0;
  int         rdy_bad = 0;
  bit         running = 1'b0;

  always @(negedge clk) begin
    if (ifc.imem_we) begin
      wq_addr.push_back(ifc.imem_addr);
      wq_data.push_back(ifc.imem_wdata);
      wq_cyc.push_back(cyc);
    end
    if (ifc.cpu_start) begin
      sq_cyc.push_back(cyc);
      running = 1'b1;
    end
    if (ifc.done) begin
      dq_cyc.push_back(cyc);
      done_cnt++;
      running = 1'b0;
    end
    if (running && ifc.in_ready) rdy_bad++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    sq_cyc.delete();
    dq_cyc.delete();
  endtask

  // Present a byte from a falling edge until a rising edge with in_ready takes it
  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = b;
    while (!acc && n < 50) begin
      acc = ifc.in_ready;
      @(negedge clk);
      n++;
    end
    ifc.in_valid = 1'b0;
    chk("byte_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic check_prog3(input string t, input int c0, input bit timed);
    logic [8:0] exp3 [3];
    exp3 = '{9'h112, 9'h034, 9'h1FF};
    chk({t, "_nwr"}, wq_addr.size(), 3);
    if (wq_addr.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk({t, "_addr"}, {24'd0, wq_addr[k]}, k);
        chk({t, "_data"}, {23'd0, wq_data[k]}, {23'd0, exp3[k]});
        if (timed) chk({t, "_wcyc"}, wq_cyc[k], c0 + 3 + 2 * k);
      end
    end
    chk({t, "_nstart"}, sq_cyc.size(), 1);
    if (timed && sq_cyc.size() == 1) chk({t, "_scyc"}, sq_cyc[0], c0 + 7);
  endtask

  initial begin
    logic [7:0] prog3 [7];
    logic [7:0] kb;
    int c_len;
    prog3 = '{8'h03, 8'h12, 8'h01, 8'h34, 8'h00, 8'hFF, 8'h01};

    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    ifc.cpu_halt = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_we",    ifc.imem_we,    0);
    chk("rst_addr",  ifc.imem_addr,  0);
    chk("rst_wdata", ifc.imem_wdata, 0);
    chk("rst_start", ifc.cpu_start,  0);
    chk("rst_busy",  ifc.busy,       0);
    chk("rst_done",  ifc.done,       0);
    chk("rst_err",   ifc.err,        0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", ifc.in_ready, 1);

    // Back-to-back 3-word program with exact timing
    clear_logs();
    c_len = cyc;
    for (int i = 0; i < 7; i++) send_byte(prog3[i]);
    repeat (2) @(negedge clk);
    check_prog3("t1", c_len, 1'b1);
    chk("t1_err",      ifc.err,      0);
    chk("t1_run_busy", ifc.busy,     1);
    chk("t1_run_rdy",  ifc.in_ready, 0);
    repeat (20) @(negedge clk);
    chk("t1_no_done", done_cnt, 0);
    chk("t1_busy20",  ifc.busy, 1);
    ifc.cpu_halt = 1'b1;
    @(negedge clk);
    ifc.cpu_halt = 1'b0;
    chk("t1_done",      ifc.done,     1);
    chk("t1_busy_fall", ifc.busy,     0);
    chk("t1_rdy_back",  ifc.in_ready, 1);
    @(negedge clk);
    chk("t1_done_pulse", ifc.done, 0);
    chk("t1_done_cnt",   done_cnt, 1);

    // Same program with in_valid toggling
    clear_logs();
    for (int i = 0; i < 7; i++) begin
      send_byte(prog3[i]);
      @(negedge clk);
    end
    @(negedge clk);
    check_prog3("t2", 0, 1'b0);
    ifc.cpu_halt = 1'b1;
    @(negedge clk);
    chk("t2_done", ifc.done, 1);
    @(negedge clk);
    // halt still high in IDLE must be ignored
    chk("t2_idle_halt_done", ifc.done, 0);
    chk("t2_idle_halt_busy", ifc.busy, 0);
    ifc.cpu_halt = 1'b0;
    @(negedge clk);
    chk("t2_done_cnt", done_cnt, 2);
    chk("t2_rdy_bad",  rdy_bad,  0);

    // Out-of-range hi bits: err set, bit 8 kept
    clear_logs();
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'h03);
    chk("t3_we",    ifc.imem_we,    1);
    chk("t3_addr",  ifc.imem_addr,  0);
    chk("t3_wdata", ifc.imem_wdata, 32'h1AA);
    chk("t3_err",   ifc.err,        1);
    chk("t3_start", ifc.cpu_start,  1);
    repeat (5) @(negedge clk);
    chk("t3_err_run", ifc.err, 1);
    ifc.cpu_halt = 1'b1;
    @(negedge clk);
    ifc.cpu_halt = 1'b0;
    chk("t3_done",     ifc.done, 1);
    chk("t3_err_done", ifc.err,  1);
    @(negedge clk);
    chk("t3_err_idle", ifc.err, 1);

    // L=0: full 256-word load; halt held high throughout
    clear_logs();
    ifc.cpu_halt = 1'b1;
    send_byte(8'h00);
    chk("t4_err_clr", ifc.err,  0);
    chk("t4_busy",    ifc.busy, 1);
    for (int k = 0; k < 256; k++) begin
      kb = k[7:0];
      send_byte(kb ^ 8'h5A);
      send_byte({7'd0, kb[3]});
    end
    repeat (3) @(negedge clk);
    ifc.cpu_halt = 1'b0;
    chk("t4_nwr", wq_addr.size(), 256);
    if (wq_addr.size() == 256) begin
      for (int k = 0; k < 256; k++) begin
        kb = k[7:0];
        chk("t4_addr", {24'd0, wq_addr[k]}, {24'd0, kb});
        chk("t4_data", {23'd0, wq_data[k]}, {23'd0, kb[3], kb ^ 8'h5A});
      end
      chk("t4_last_addr", {24'd0, wq_addr[255]}, 32'hFF);
    end
    chk("t4_nstart", sq_cyc.size(), 1);
    chk("t4_ndone",  dq_cyc.size(), 1);
    if (sq_cyc.size() == 1 && wq_cyc.size() == 256) chk("t4_start_cyc", sq_cyc[0], wq_cyc[255]);
    if (sq_cyc.size() == 1 && dq_cyc.size() == 1) chk("t4_done_cyc", dq_cyc[0], sq_cyc[0] + 2);

    // Reset while in HI after 2 of 5 words
    clear_logs();
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h00);
    send_byte(8'h22);
    send_byte(8'h01);
    send_byte(8'h33);
    chk("t5_pre_addr",  ifc.imem_addr,  1);
    chk("t5_pre_wdata", ifc.imem_wdata, 32'h122);
    chk("t5_pre_busy",  ifc.busy,       1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_we",    ifc.imem_we,    0);
    chk("t5_rst_addr",  ifc.imem_addr,  0);
    chk("t5_rst_wdata", ifc.imem_wdata, 0);
    chk("t5_rst_start", ifc.cpu_start,  0);
    chk("t5_rst_busy",  ifc.busy,       0);
    chk("t5_rst_done",  ifc.done,       0);
    chk("t5_rst_err",   ifc.err,        0);
    chk("t5_rst_rdy",   ifc.in_ready,   1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    send_byte(8'h01);
    send_byte(8'h77);
    send_byte(8'h00);
    chk("t5_we",    ifc.imem_we,    1);
    chk("t5_addr",  ifc.imem_addr,  0);
    chk("t5_wdata", ifc.imem_wdata, 32'h077);
    chk("t5_start", ifc.cpu_start,  1);
    @(negedge clk);
    ifc.cpu_halt = 1'b1;
    @(negedge clk);
    ifc.cpu_halt = 1'b0;
    chk("t5_done", ifc.done, 1);
    @(negedge clk);
    chk("t5_nwr", wq_addr.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that is the writing side of the instruction memory the stack CPU fetches from. It accepts a byte stream over a valid/ready handshake, packs byte pairs into instruction words, and writes them sequentially into instruction memory from address 0. After the last word it pulses the CPU `start`, waits for `halt`, and then returns to idle ready for the next program.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction memory address width; matches the CPU program counter.
- `INSTR_W`, default 9: instruction word width; legal range 9..16.

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  reset: asynchronous assert, active-low.
- `in_valid`  input  1  stream byte valid.
- `in_data`  input  8  stream byte.
- `in_ready`  output  1  loader can accept a byte; a byte transfers when `in_valid && in_ready` at a rising edge.
- `imem_we`  output  1  instruction memory write enable, one cycle per word.
- `imem_addr`  output  ADDR_W  write address.
- `imem_wdata`  output  INSTR_W  write data.
- `cpu_start`  output  1  one-cycle start pulse to the CPU.
- `cpu_halt`  input  1  CPU halt flag.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse when `cpu_halt` is seen in RUN.
- `err`  output  1  sticky format error.

## Operation
- Stream format: length byte L, then L words of 2 bytes each, low byte first. L=0 means 2^ADDR_W words. An L larger than 2^ADDR_W is not possible at the default ADDR_W.
- Word = {hi[INSTR_W-9:0], lo}. Any set bit in hi above bit INSTR_W-9 sets `err`. The word is still written with those bits dropped.
- FSM states:
  - IDLE: `in_ready`=1. On accepted byte, load the remaining count (9 bits) with L, or with 2^ADDR_W if L=0. Clear the address counter and `err`. Go to LO.
  - LO: `in_ready`=1. On accepted byte, latch lo and go to HI.
  - HI: `in_ready`=1. On accepted byte, register the write (`imem_we`, addr, data) for the next cycle, increment the address, and decrement remaining. If remaining becomes 0, go to START; otherwise go to LO.
  - START: `in_ready`=0. `cpu_start`=1 for exactly this one cycle. Go to RUN.
  - RUN: `in_ready`=0. When `cpu_halt`=1, pulse `done` and go to IDLE.
- `cpu_halt` is ignored in every state except RUN.
- Address wraps modulo 2^ADDR_W. With L=0, the last write goes to address 2^ADDR_W-1 and the counter wraps to 0.
- `in_valid` low in LO/HI stalls the FSM indefinitely. There is no timeout.

## Timing
- Reset values: state IDLE, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_start`=0, `busy`=0, `done`=0, `err`=0. `in_ready` is decoded from the state, so it is 1 once `rst_n` deasserts.
- `imem_we`, `imem_addr`, `imem_wdata`, `cpu_start` and `done` are all registered.
- Write latency: `imem_we` is high in the cycle after the hi byte is accepted.
- START is entered in the same edge as the final write is registered. This puts the last `imem_we` and `cpu_start` in the same cycle; the write still completes before the CPU's first fetch edge.
- Throughput: one byte per cycle, so one word per 2 cycles.
- Total load time: a program of N words with back-to-back bytes has its last write 2N+1 cycles after the length byte, with `cpu_start` in that same cycle.
- `done` is asserted in the cycle after `cpu_halt` is sampled in RUN. `in_ready` is high again in that same cycle.
- Reset mid-load or mid-run returns to IDLE immediately and drops every output to its reset value. The partial program stays in memory and is not invalidated.

## Structure
- Package `imem_loader_pkg` holds:
  - the state enum `loader_state_t` {IDLE, LO, HI, START, RUN};
  - default widths `ADDR_W_DEF`=8 and `INSTR_W_DEF`=9;
  - `HDR_ZERO_MEANS_FULL`=1.
- Single module with no sub-module: an FSM plus address, remaining and lo-byte registers.
- Instruction memory must expose a write port; the loader never reads it.

## Test plan
- Reset release, then stream 03, (12,01), (34,00), (FF,01) -> writes at addr 0,1,2 of 0x112, 0x034, 0x1FF on successive odd cycles; one `cpu_start` in the cycle of the addr-2 write; `err`=0.
- Same stream with `in_valid` toggling every other cycle -> identical writes, no duplicate or lost word, `in_ready` never high in START/RUN.
- In RUN, hold `cpu_halt` low for 20 cycles, then high -> exactly one `done` pulse one cycle later, `busy` falls, next length byte accepted.
- L=00 followed by 512 bytes -> 256 writes to addresses 0..255, the last at 0xFF, then `cpu_start`.
- hi byte 0x03 with INSTR_W=9 -> `err`=1 and data bit 8 = 1. `err` stays set through RUN and clears on the next accepted length byte.
- `rst_n` low in HI after 2 of 5 words -> all outputs at reset values asynchronously. After release, a fresh 1-word program loads at addr 0.
